axis_len_checker: RTL and testbench

//  Stage directly downstream of the crypto datapath block. Passes 256-bit AXI-Stream packets through

---
 rtl/axis_len_checker_pkg.sv | 18 +
 rtl/axis_skid_buffer.sv | 65 ++++++
 rtl/axis_len_checker.sv | 152 +++++++++++++++
 tb/tb_axis_len_checker.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_len_checker_pkg.sv
// Shared definitions for the AXI-Stream length checker: tuser length field
// location, popcount/length widths and the checker FSM state encoding.
package axis_len_checker_pkg;

    // Packet length in bytes lives in tuser[LEN_HI:LEN_LO] of the first beat.
    localparam int LEN_LO   = 0;
    localparam int LEN_HI   = 15;
    localparam int LEN_W    = LEN_HI - LEN_LO + 1;

    // Strobe popcount of one 32-byte beat ranges 0..32.
    localparam int POPCNT_W = 6;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer (main + skid register) for a flattened AXI-Stream
// payload. One cycle of latency, full throughput, and an upstream ready that
// comes straight from a flop so there is no combinational path from i_ready.
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_ready;

    logic             w_in_acc;
    logic             w_main_free;
    logic             w_skid_valid_nxt;

    // Upstream ready is low exactly when the skid entry is occupied, so an
    // accepted beat always has somewhere to land.
    assign w_in_acc         = i_valid & r_ready;
    assign w_main_free      = ~r_main_valid | i_ready;
    assign w_skid_valid_nxt = w_main_free ? 1'b0 : (r_skid_valid | w_in_acc);

    assign o_ready = r_ready;
    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;

    // Main register feeds the output; skid catches a beat when the output stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_ready      <= 1'b0;
        end else begin
            if (w_main_free) begin
                if (r_skid_valid) begin
                    // Ready was low, so no new beat arrives while draining skid.
                    r_main_valid <= 1'b1;
                    r_main_data  <= r_skid_data;
                end else begin
                    r_main_valid <= w_in_acc;
                    if (w_in_acc) begin
                        r_main_data <= i_data;
                    end
                end
            end else if (w_in_acc) begin
                r_skid_data <= i_data;
            end
            r_skid_valid <= w_skid_valid_nxt;
            r_ready      <= ~w_skid_valid_nxt;
        end
    end

endmodule

// File: rtl/axis_len_checker.sv
// Pass-through AXI-Stream stage behind the crypto datapath. Beats go through
// a skid buffer untouched; in parallel the accepted strobe bytes of each
// packet are totalled and compared with the tuser length field of its first
// beat. Packet and length-error counters are exported to the register block.
module axis_len_checker
    import axis_len_checker_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                              axi_aclk,
    input  logic                              axi_areset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,

    input  logic                              cnt_clear,
    output logic [CNT_WIDTH-1:0]              pkt_count,
    output logic [CNT_WIDTH-1:0]              len_err_count,
    output logic                              len_err
);

    localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int PAY_W  = C_S_AXIS_DATA_WIDTH + STRB_W + C_S_AXIS_TUSER_WIDTH + 1;

    // Number of valid bytes in a beat.
    function automatic logic [POPCNT_W-1:0] popcount(input logic [STRB_W-1:0] v);
        logic [POPCNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < STRB_W; i++) begin
            cnt = cnt + POPCNT_W'(v[i]);
        end
        return cnt;
    endfunction

    // Byte accumulation that sticks at all-ones instead of wrapping, so an
    // oversize packet can never alias onto a small valid length.
    function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a,
                                                  input logic [POPCNT_W-1:0] b);
        logic [LEN_W:0] s;
        s = {1'b0, a} + (LEN_W + 1)'(b);
        return s[LEN_W] ? {LEN_W{1'b1}} : s[LEN_W-1:0];
    endfunction

    logic [PAY_W-1:0]     w_s_payload;
    logic [PAY_W-1:0]     w_m_payload;
    logic                 w_s_ready;

    logic                 w_accept;
    logic                 w_compare;
    logic                 w_mismatch;
    logic [POPCNT_W-1:0]  w_popcnt;
    logic [LEN_W-1:0]     w_acc_nxt;
    logic [LEN_W-1:0]     w_exp_len;

    state_t               r_state;
    logic [LEN_W-1:0]     r_exp_len;
    logic [LEN_W-1:0]     r_acc;
    logic                 r_len_err;
    logic [CNT_WIDTH-1:0] r_pkt_count;
    logic [CNT_WIDTH-1:0] r_len_err_count;

    assign w_s_payload = {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};
    assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = w_m_payload;
    assign s_axis_tready = w_s_ready;

    axis_skid_buffer #(
        .WIDTH   (PAY_W)
    ) u_skid (
        .clk     (axi_aclk),
        .rst     (axi_areset),
        .i_data  (w_s_payload),
        .i_valid (s_axis_tvalid),
        .o_ready (w_s_ready),
        .o_data  (w_m_payload),
        .o_valid (m_axis_tvalid),
        .i_ready (m_axis_tready)
    );

    // The first beat of a packet starts a fresh total against its own tuser
    // length; later beats add to the running total against the latched length.
    assign w_accept   = s_axis_tvalid & w_s_ready;
    assign w_compare  = w_accept & s_axis_tlast;
    assign w_popcnt   = popcount(s_axis_tstrb);
    assign w_acc_nxt  = (r_state == ST_IDLE) ? LEN_W'(w_popcnt) : sat_add(r_acc, w_popcnt);
    assign w_exp_len  = (r_state == ST_IDLE) ? s_axis_tuser[LEN_HI:LEN_LO] : r_exp_len;
    assign w_mismatch = (w_acc_nxt != w_exp_len);

    // Packet framing FSM: tracks first/continuation beats and the byte total.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_state   <= ST_IDLE;
            r_exp_len <= '0;
            r_acc     <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_exp_len <= s_axis_tuser[LEN_HI:LEN_LO];
                    if (!s_axis_tlast) begin
                        r_state <= ST_IN_PKT;
                    end
                end
                ST_IN_PKT: begin
                    if (s_axis_tlast) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Counters and error pulse; a register clear wins over a same-cycle increment.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_len_err       <= 1'b0;
            r_pkt_count     <= '0;
            r_len_err_count <= '0;
        end else begin
            r_len_err <= w_compare & w_mismatch;
            if (cnt_clear) begin
                r_pkt_count     <= '0;
                r_len_err_count <= '0;
            end else if (w_compare) begin
                r_pkt_count <= r_pkt_count + 1'b1;
                if (w_mismatch) begin
                    r_len_err_count <= r_len_err_count + 1'b1;
                end
            end
        end
    end

    assign pkt_count     = r_pkt_count;
    assign len_err_count = r_len_err_count;
    assign len_err       = r_len_err;

endmodule

// File: tb/tb_axis_len_checker.sv
// Self-checking bench for axis_len_checker. A second instance with narrow
// counters shares the stimulus so counter wrap-around can be reached quickly.
module tb_axis_len_checker;

    localparam int PW = 256 + 32 + 128 + 1;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [255:0] s_tdata;
    logic [31:0]  s_tstrb;
    logic [127:0] s_tuser;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic [255:0] m_tdata;
    logic [31:0]  m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic         cnt_clear;
    logic [31:0]  pkt_count;
    logic [31:0]  len_err_count;
    logic         len_err;

    logic [255:0] m2_tdata;
    logic [31:0]  m2_tstrb;
    logic [127:0] m2_tuser;
    logic         m2_tvalid;
    logic         m2_tlast;
    logic         s2_tready;
    logic [3:0]   pkt2;
    logic [3:0]   err2;
    logic         len_err2;

    axis_len_checker u_dut (
        .axi_aclk      (clk),
        .axi_areset    (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .cnt_clear     (cnt_clear),
        .pkt_count     (pkt_count),
        .len_err_count (len_err_count),
        .len_err       (len_err)
    );

    axis_len_checker #(.CNT_WIDTH(4)) u_dut_narrow (
        .axi_aclk      (clk),
        .axi_areset    (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s2_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m2_tdata),
        .m_axis_tstrb  (m2_tstrb),
        .m_axis_tuser  (m2_tuser),
        .m_axis_tvalid (m2_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m2_tlast),
        .cnt_clear     (cnt_clear),
        .pkt_count     (pkt2),
        .len_err_count (err2),
        .len_err       (len_err2)
    );

    int           errors = 0;
    int           checks = 0;
    logic [PW-1:0] q[$];
    logic [31:0]  mdl_pkt;
    logic [31:0]  mdl_err;
    logic         mdl_pend;
    int           out_cnt = 0;
    int           pulse_cnt = 0;
    int           m_mode = 0;

    // Reference model: expected beats in flight, packet byte totals, counters.
    task automatic monitor();
        int            acc;
        logic [15:0]   elen;
        logic          in_pkt;
        logic          nxt_pend;
        acc = 0; elen = '0; in_pkt = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                mdl_pkt = '0; mdl_err = '0; mdl_pend = 1'b0;
                in_pkt = 1'b0; acc = 0;
            end else begin
                checks++;
                if (m_tvalid !== (q.size() > 0)) begin
                    errors++;
                    $display("FAIL m_tvalid: got %b, expected %b at %0t", m_tvalid, q.size() > 0, $time);
                end
                if (q.size() == 2) begin
                    checks++;
                    if (s_tready !== 1'b0) begin
                        errors++;
                        $display("FAIL ready_when_full: got %b, expected 0 at %0t", s_tready, $time);
                    end
                end
                if (q.size() > 0) begin
                    checks++;
                    if ({m_tdata, m_tstrb, m_tuser, m_tlast} !== q[0]) begin
                        errors++;
                        $display("FAIL out_beat: got strb %h last %b, expected strb %h last %b at %0t",
                                 m_tstrb, m_tlast, q[0][160:129], q[0][0], $time);
                    end
                end
                checks++;
                if (pkt_count !== mdl_pkt || len_err_count !== mdl_err) begin
                    errors++;
                    $display("FAIL counters: got pkt %0d err %0d, expected pkt %0d err %0d at %0t",
                             pkt_count, len_err_count, mdl_pkt, mdl_err, $time);
                end
                checks++;
                if (pkt2 !== mdl_pkt[3:0] || err2 !== mdl_err[3:0]) begin
                    errors++;
                    $display("FAIL narrow_counters: got pkt %0d err %0d, expected pkt %0d err %0d at %0t",
                             pkt2, err2, mdl_pkt[3:0], mdl_err[3:0], $time);
                end
                checks++;
                if (len_err !== mdl_pend || len_err2 !== mdl_pend) begin
                    errors++;
                    $display("FAIL len_err: got %b/%b, expected %b at %0t", len_err, len_err2, mdl_pend, $time);
                end
                if (len_err === 1'b1) pulse_cnt++;

                nxt_pend = 1'b0;
                if (m_tvalid && m_tready && q.size() > 0) begin
                    void'(q.pop_front());
                    out_cnt++;
                end
                if (s_tvalid && s_tready) begin
                    q.push_back({s_tdata, s_tstrb, s_tuser, s_tlast});
                    if (!in_pkt) begin
                        elen = s_tuser[15:0];
                        acc  = 0;
                    end
                    acc = acc + $countones(s_tstrb);
                    if (acc > 65535) acc = 65535;
                    if (s_tlast) begin
                        mdl_pkt++;
                        if (acc != int'(elen)) begin
                            mdl_err++;
                            nxt_pend = 1'b1;
                        end
                        in_pkt = 1'b0;
                    end else begin
                        in_pkt = 1'b1;
                    end
                end
                mdl_pend = nxt_pend;
                if (cnt_clear) begin
                    mdl_pkt = '0;
                    mdl_err = '0;
                end
            end
        end
    endtask

    task automatic tready_driver();
        forever begin
            @(posedge clk); #1;
            case (m_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_counters();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
    endtask

    // Presents one beat and holds it until the slave side accepts it.
    task automatic send_beat(input logic [31:0] st, input logic [15:0] len,
                             input logic last, output logic [255:0] d);
        logic [127:0] u;
        logic         ok;
        int           n;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        for (int i = 0; i < 4; i++) u[i*32 +: 32] = $urandom;
        u[15:0]  = len;
        s_tdata  = d;
        s_tstrb  = st;
        s_tuser  = u;
        s_tlast  = last;
        s_tvalid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = s_tready;
            tick();
            n++;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", n);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending, expected 0", q.size());
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || m_tdata !== '0 || m_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got tvalid %b tready %b, expected 0 0", m_tvalid, s_tready);
        end
        checks++;
        if (pkt_count !== 32'd0 || len_err_count !== 32'd0 || len_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_counters: got pkt %0d err %0d pulse %b, expected 0 0 0",
                     pkt_count, len_err_count, len_err);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, expected 1", s_tready);
        end
    endtask

    task automatic test_pkt(input logic [15:0] len, input logic [31:0] exp_err, input int exp_pulses);
        logic [255:0] d;
        int           p0;
        clear_counters();
        p0 = pulse_cnt;
        send_beat(32'hFFFF_FFFF, len, 1'b0, d);
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== d) begin
            errors++;
            $display("FAIL latency_beat0: got valid %b data %h, expected valid 1 data %h", m_tvalid, m_tdata, d);
        end
        send_beat(32'h0FFF_FFFF, len, 1'b1, d);
        s_tvalid = 1'b0;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== d || m_tlast !== 1'b1) begin
            errors++;
            $display("FAIL latency_beat1: got valid %b last %b, expected valid 1 last 1", m_tvalid, m_tlast);
        end
        wait_drain();
        checks++;
        if (pkt_count !== 32'd1 || len_err_count !== exp_err || pulse_cnt - p0 != exp_pulses) begin
            errors++;
            $display("FAIL pkt_len%0d: got pkt %0d err %0d pulses %0d, expected 1 %0d %0d",
                     len, pkt_count, len_err_count, pulse_cnt - p0, exp_err, exp_pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] d;
        logic [31:0]  st[3];
        int           sum, bad, exp_bad, o0;
        logic [15:0]  len;
        clear_counters();
        exp_bad = 0;
        o0 = out_cnt;
        m_mode = 1;
        for (int p = 0; p < 100; p++) begin
            sum = 0;
            for (int b = 0; b < 3; b++) begin
                st[b] = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
                sum += $countones(st[b]);
            end
            bad = $urandom_range(0, 1);
            exp_bad += bad;
            len = 16'(bad ? sum + $urandom_range(1, 7) : sum);
            for (int b = 0; b < 3; b++) send_beat(st[b], len, b == 2, d);
        end
        s_tvalid = 1'b0;
        m_mode = 0;
        wait_drain();
        checks++;
        if (pkt_count !== 32'd100 || len_err_count !== 32'(exp_bad)) begin
            errors++;
            $display("FAIL b2b_counts: got pkt %0d err %0d, expected 100 %0d", pkt_count, len_err_count, exp_bad);
        end
        checks++;
        if (out_cnt - o0 != 300) begin
            errors++;
            $display("FAIL b2b_beats: got %0d beats out, expected 300", out_cnt - o0);
        end
        checks++;
        if (pkt2 !== 4'd4) begin
            errors++;
            $display("FAIL b2b_narrow_wrap: got %0d, expected 4", pkt2);
        end
    endtask

    task automatic test_wrap_clear();
        logic [255:0] d;
        int           p0;
        clear_counters();
        for (int p = 0; p < 16; p++) begin
            send_beat(32'hFFFF_FFFF, (p == 0) ? 16'd31 : 16'd32, 1'b1, d);
        end
        s_tvalid = 1'b0;
        wait_drain();
        checks++;
        if (pkt_count !== 32'd16 || len_err_count !== 32'd1 || pkt2 !== 4'd0 || err2 !== 4'd1) begin
            errors++;
            $display("FAIL wrap: got pkt %0d/%0d err %0d/%0d, expected 16/0 1/1",
                     pkt_count, pkt2, len_err_count, err2);
        end
        p0 = pulse_cnt;
        cnt_clear = 1'b1;
        send_beat(32'hFFFF_FFFF, 16'd7, 1'b1, d);
        cnt_clear = 1'b0;
        s_tvalid  = 1'b0;
        wait_drain();
        checks++;
        if (pkt_count !== 32'd0 || len_err_count !== 32'd0 || pulse_cnt - p0 != 1) begin
            errors++;
            $display("FAIL clear_priority: got pkt %0d err %0d pulses %0d, expected 0 0 1",
                     pkt_count, len_err_count, pulse_cnt - p0);
        end
    endtask

    task automatic test_saturation();
        logic [255:0] d;
        clear_counters();
        for (int b = 0; b < 2050; b++) send_beat(32'hFFFF_FFFF, 16'hFFFF, b == 2049, d);
        s_tvalid = 1'b0;
        wait_drain();
        checks++;
        if (pkt_count !== 32'd1 || len_err_count !== 32'd0) begin
            errors++;
            $display("FAIL saturation: got pkt %0d err %0d, expected 1 0", pkt_count, len_err_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] d;
        int           p0;
        send_beat(32'hFFFF_FFFF, 16'd32, 1'b1, d);
        send_beat(32'hFFFF_FFFF, 16'd96, 1'b0, d);
        rst = 1'b1;
        s_tvalid = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || m_tdata !== '0 || pkt_count !== 32'd0
            || len_err_count !== 32'd0 || len_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got valid %b ready %b pkt %0d, expected 0 0 0",
                     m_tvalid, s_tready, pkt_count);
        end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        p0 = pulse_cnt;
        send_beat(32'hFFFF_FFFF, 16'd32, 1'b1, d);
        s_tvalid = 1'b0;
        wait_drain();
        checks++;
        if (pkt_count !== 32'd1 || len_err_count !== 32'd0 || pulse_cnt - p0 != 0) begin
            errors++;
            $display("FAIL after_reset_pkt: got pkt %0d err %0d pulses %0d, expected 1 0 0",
                     pkt_count, len_err_count, pulse_cnt - p0);
        end
    endtask

    task automatic test_hole();
        logic [255:0] d;
        int           p0;
        clear_counters();
        p0 = pulse_cnt;
        m_mode = 2;
        send_beat(32'h0000_003C, 16'd4, 1'b1, d);
        s_tvalid = 1'b0;
        m_mode = 0;
        wait_drain();
        checks++;
        if (pkt_count !== 32'd1 || len_err_count !== 32'd0 || pulse_cnt - p0 != 0) begin
            errors++;
            $display("FAIL strobe_hole: got pkt %0d err %0d pulses %0d, expected 1 0 0",
                     pkt_count, len_err_count, pulse_cnt - p0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        s_tdata   = '0;
        s_tstrb   = '0;
        s_tuser   = '0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        m_tready  = 1'b1;
        cnt_clear = 1'b0;
        mdl_pkt   = '0;
        mdl_err   = '0;
        mdl_pend  = 1'b0;
        fork
            monitor();
            tready_driver();
        join_none
        test_reset();
        test_pkt(16'd60, 32'd0, 0);
        test_pkt(16'd64, 32'd1, 1);
        test_back_to_back();
        test_wrap_clear();
        test_saturation();
        test_reset_mid();
        test_hole();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
